// File: rtl/xor_absorb_stage.sv
`default_nettype none
// ============================================================================
// xor_absorb_stage: ASCON input stage - absorbs a padded rate block, key and domain bit
// Revision: 1.0
// ============================================================================

package xor_absorb_pkg;
   typedef logic [4:0][63:0] t_state_array;
endpackage

module xor_absorb_stage
   import xor_absorb_pkg::*;
#(
   parameter int RATE_WORDS = 1,
   parameter int CNT_WIDTH  = 16,
   localparam int BYTES_W   = $clog2(8*RATE_WORDS+1)
) (
   input  logic                    i_clock,
   input  logic                    i_reset_n,
   input  t_state_array            i_state,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [64*RATE_WORDS-1:0] i_data,
   input  logic [BYTES_W-1:0]      i_data_bytes,
   input  logic [127:0]            i_key,
   input  logic                    i_enable_xor_data,
   input  logic                    i_enable_pad,
   input  logic                    i_enable_xor_key,
   input  logic                    i_domain_sep,
   input  logic                    i_clear_count,
   output t_state_array            o_state,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [CNT_WIDTH-1:0]    o_block_count
);

   localparam int NBYTES = 8 * RATE_WORDS;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   generate
      if (RATE_WORDS != 1 && RATE_WORDS != 2) begin : g_bad_rate
         $error("xor_absorb_stage: RATE_WORDS must be 1 or 2");
      end
   endgenerate

   typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} fsm_t;

   fsm_t                      fsm_q;
   fsm_t                      fsm_d;
   logic                      accept;
   logic                      absorb;
   int                        pad_len;
   logic [64*RATE_WORDS-1:0]  block;
   t_state_array              next_state;
   t_state_array              state_q;
   logic [CNT_WIDTH-1:0]      count_q;

   assign o_valid       = (fsm_q == FULL);
   assign o_ready       = !o_valid || i_ready;
   assign accept        = i_valid && o_ready;
   assign absorb        = accept && i_enable_xor_data;
   assign o_state       = state_q;
   assign o_block_count = count_q;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) fsm_q <= EMPTY;
      else            fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         EMPTY:   if (accept) fsm_d = FULL;
         FULL:    if (i_ready && !accept) fsm_d = EMPTY;
         default: fsm_d = EMPTY;
      endcase
   end

   // Byte b lives in row b/8, big-endian within the row; lengths past the block are clamped
   always_comb begin
      pad_len = 32'(i_data_bytes);
      if (pad_len > NBYTES) pad_len = NBYTES;
      block = i_data;
      if (i_enable_pad) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (b == pad_len)     block[64*(b/8) + 56 - 8*(b%8) +: 8] = 8'h80;
            else if (b > pad_len) block[64*(b/8) + 56 - 8*(b%8) +: 8] = 8'h00;
         end
      end
   end

   // Domain bit is applied last so it lands on row 4 even when the key reaches row 3
   always_comb begin
      next_state = i_state;
      if (i_enable_xor_data) begin
         for (int w = 0; w < RATE_WORDS; w++)
            next_state[w] = i_state[w] ^ block[64*w +: 64];
      end
      if (i_enable_xor_key) begin
         next_state[RATE_WORDS]   = next_state[RATE_WORDS]   ^ i_key[127:64];
         next_state[RATE_WORDS+1] = next_state[RATE_WORDS+1] ^ i_key[63:0];
      end
      if (i_domain_sep) next_state[4][0] = ~next_state[4][0];
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n)  state_q <= '0;
      else if (accept) state_q <= next_state;
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n)                    count_q <= '0;
      else if (i_clear_count)            count_q <= absorb ? CNT_ONE : '0;
      else if (absorb && !(&count_q))    count_q <= count_q + CNT_ONE;
   end

endmodule

`default_nettype wire

// File: tb/tb_xor_absorb_stage.sv
`default_nettype none
// ============================================================================
// tb_xor_absorb_stage: directed scoreboard bench for RATE_WORDS=1 and RATE_WORDS=2/CNT_WIDTH=2
// Revision: 1.0
// ============================================================================

module tb_xor_absorb_stage;
   import xor_absorb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [127:0] key;

   t_state_array a_st, a_ost;
   logic         a_valid, a_ready, a_ovalid, a_iready, a_xd, a_pad, a_xk, a_ds, a_clr;
   logic [63:0]  a_data;
   logic [3:0]   a_bytes;
   logic [15:0]  a_cnt;

   t_state_array b_st, b_ost;
   logic         b_valid, b_ready, b_ovalid, b_iready, b_xd, b_pad, b_xk, b_ds, b_clr;
   logic [127:0] b_data;
   logic [4:0]   b_bytes;
   logic [1:0]   b_cnt;

   int checks   = 0;
   int failures = 0;

   t_state_array qa_st[$], qb_st[$];
   logic [15:0]  qa_cnt[$], qb_cnt[$];
   t_state_array a_exp_st, b_exp_st;
   logic [15:0]  a_exp_cnt, b_exp_cnt;

   t_state_array bp_st[3];
   t_state_array bp_exp[3];
   logic [63:0]  bp_d[3];

   xor_absorb_stage #(.RATE_WORDS(1), .CNT_WIDTH(16)) u_a (
      .i_clock(clk), .i_reset_n(rst_n), .i_state(a_st), .i_valid(a_valid), .o_ready(a_ready),
      .i_data(a_data), .i_data_bytes(a_bytes), .i_key(key), .i_enable_xor_data(a_xd),
      .i_enable_pad(a_pad), .i_enable_xor_key(a_xk), .i_domain_sep(a_ds), .i_clear_count(a_clr),
      .o_state(a_ost), .o_valid(a_ovalid), .i_ready(a_iready), .o_block_count(a_cnt)
   );

   xor_absorb_stage #(.RATE_WORDS(2), .CNT_WIDTH(2)) u_b (
      .i_clock(clk), .i_reset_n(rst_n), .i_state(b_st), .i_valid(b_valid), .o_ready(b_ready),
      .i_data(b_data), .i_data_bytes(b_bytes), .i_key(key), .i_enable_xor_data(b_xd),
      .i_enable_pad(b_pad), .i_enable_xor_key(b_xk), .i_domain_sep(b_ds), .i_clear_count(b_clr),
      .o_state(b_ost), .o_valid(b_ovalid), .i_ready(b_iready), .o_block_count(b_cnt)
   );

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare completed outputs and record accepted inputs at the falling edge, then step one cycle
   task automatic tick();
      t_state_array es;
      logic [15:0]  ec;
      @(negedge clk);
      if (a_ovalid === 1'b1 && a_iready) begin
         chk("a_out_expected", 320'(qa_st.size() != 0), 320'(1));
         if (qa_st.size() != 0) begin
            es = qa_st.pop_front();
            ec = qa_cnt.pop_front();
            chk("a_state", a_ost, es);
            chk("a_count", 320'(a_cnt), 320'(ec));
         end
      end
      if (b_ovalid === 1'b1 && b_iready) begin
         chk("b_out_expected", 320'(qb_st.size() != 0), 320'(1));
         if (qb_st.size() != 0) begin
            es = qb_st.pop_front();
            ec = qb_cnt.pop_front();
            chk("b_state", b_ost, es);
            chk("b_count", 320'(b_cnt), 320'(ec));
         end
      end
      if (rst_n && a_valid && a_ready === 1'b1) begin
         qa_st.push_back(a_exp_st);
         qa_cnt.push_back(a_exp_cnt);
      end
      if (rst_n && b_valid && b_ready === 1'b1) begin
         qb_st.push_back(b_exp_st);
         qb_cnt.push_back(b_exp_cnt);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; key = '0;
      a_st = '0; a_valid = 0; a_iready = 1; a_xd = 0; a_pad = 0; a_xk = 0; a_ds = 0; a_clr = 0;
      a_data = '0; a_bytes = '0;
      b_st = '0; b_valid = 0; b_iready = 1; b_xd = 0; b_pad = 0; b_xk = 0; b_ds = 0; b_clr = 0;
      b_data = '0; b_bytes = '0;
      a_exp_st = '0; a_exp_cnt = '0; b_exp_st = '0; b_exp_cnt = '0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_a_valid", 320'(a_ovalid), 320'(0));
      chk("rst_a_state", a_ost, 320'(0));
      chk("rst_a_count", 320'(a_cnt), 320'(0));
      chk("rst_a_ready", 320'(a_ready), 320'(1));
      chk("rst_b_valid", 320'(b_ovalid), 320'(0));
      chk("rst_b_count", 320'(b_cnt), 320'(0));

      // RATE_WORDS=1: plain absorb, then padding variants
      a_valid = 1; a_xd = 1; a_clr = 1; a_data = 64'h0123456789ABCDEF;
      a_exp_st = '0; a_exp_st[0] = 64'h0123456789ABCDEF; a_exp_cnt = 1;
      tick();
      chk("a_valid_latency", 320'(a_ovalid), 320'(1));
      a_clr = 0; a_pad = 1; a_bytes = 3; a_data = 64'hAABBCCDDEEFF0011;
      a_exp_st[0] = 64'hAABBCC8000000000; a_exp_cnt = 2;
      tick();
      a_bytes = 0;
      a_exp_st[0] = 64'h8000000000000000; a_exp_cnt = 3;
      tick();
      a_bytes = 12; a_data = 64'hDEADBEEFCAFEF00D;
      a_exp_st[0] = 64'hDEADBEEFCAFEF00D; a_exp_cnt = 4;
      tick();
      a_bytes = 8;
      a_exp_cnt = 5;
      tick();
      a_pad = 0; a_bytes = 3; a_data = 64'h1122334455667788;
      a_exp_st[0] = 64'h1122334455667788; a_exp_cnt = 6;
      tick();

      // RATE_WORDS=1: key into rows 1..2 and domain bit over a non-zero state
      a_xd = 0; a_xk = 1; a_ds = 1; key = 128'h00112233445566778899AABBCCDDEEFF;
      a_st[0] = 64'h1111111111111111; a_st[1] = 64'h2222222222222222;
      a_st[2] = 64'h3333333333333333; a_st[3] = 64'h4444444444444444;
      a_st[4] = 64'h5555555555555555;
      a_exp_st[0] = 64'h1111111111111111; a_exp_st[1] = 64'h2233001166774455;
      a_exp_st[2] = 64'hBBAA9988FFEEDDCC; a_exp_st[3] = 64'h4444444444444444;
      a_exp_st[4] = 64'h5555555555555554; a_exp_cnt = 6;
      tick();

      // Clear on a data accept, then clear with no accept
      a_xk = 0; a_ds = 0; a_xd = 1; a_clr = 1; a_st = '0; a_data = 64'h5;
      a_exp_st = '0; a_exp_st[0] = 64'h5; a_exp_cnt = 1;
      tick();
      a_valid = 0; a_clr = 0;
      tick();
      chk("a_empty_after_drain", 320'(a_ovalid), 320'(0));
      a_clr = 1;
      tick();
      a_clr = 0;
      chk("a_clear_no_accept", 320'(a_cnt), 320'(0));

      // Backpressure: second input held by the source while the first result is stalled
      for (int i = 0; i < 3; i++) begin
         for (int r = 0; r < 5; r++) bp_st[i][r] = {$urandom(), $urandom()};
         bp_d[i] = {$urandom(), $urandom()};
         bp_exp[i] = bp_st[i];
         bp_exp[i][0] = bp_st[i][0] ^ bp_d[i];
      end
      a_valid = 1; a_st = bp_st[0]; a_data = bp_d[0]; a_exp_st = bp_exp[0]; a_exp_cnt = 1;
      tick();
      a_st = bp_st[1]; a_data = bp_d[1]; a_exp_st = bp_exp[1]; a_exp_cnt = 2; a_iready = 0;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("bp_ready_low", 320'(a_ready), 320'(0));
         chk("bp_valid_held", 320'(a_ovalid), 320'(1));
         chk("bp_state_held", a_ost, bp_exp[0]);
      end
      a_iready = 1;
      tick();
      a_st = bp_st[2]; a_data = bp_d[2]; a_exp_st = bp_exp[2]; a_exp_cnt = 3;
      tick();
      a_valid = 0;
      tick();
      chk("bp_all_drained", 320'(qa_st.size()), 320'(0));

      // RATE_WORDS=2: key into rows 2..3, domain bit on row 4
      b_valid = 1; b_xk = 1; b_ds = 1; b_clr = 1;
      b_exp_st = '0; b_exp_st[2] = 64'h0011223344556677; b_exp_st[3] = 64'h8899AABBCCDDEEFF;
      b_exp_st[4] = 64'h1; b_exp_cnt = 0;
      tick();
      b_xk = 0; b_ds = 0; b_clr = 0; b_xd = 1; b_pad = 1; b_bytes = 11;
      b_data = {64'h08090A0B0C0D0E0F, 64'h0001020304050607};
      b_exp_st = '0; b_exp_st[0] = 64'h0001020304050607; b_exp_st[1] = 64'h08090A8000000000;
      b_exp_cnt = 1;
      tick();
      b_bytes = 16;
      b_exp_st[1] = 64'h08090A0B0C0D0E0F; b_exp_cnt = 2;
      tick();
      b_bytes = 0;
      b_exp_st[0] = 64'h8000000000000000; b_exp_st[1] = 64'h0; b_exp_cnt = 3;
      tick();
      b_bytes = 20;
      b_exp_st[0] = 64'h0001020304050607; b_exp_st[1] = 64'h08090A0B0C0D0E0F; b_exp_cnt = 3;
      tick();
      b_pad = 0; b_st[0] = 64'hFFFFFFFFFFFFFFFF; b_st[1] = 64'h0F0F0F0F0F0F0F0F;
      b_st[4] = 64'hAAAAAAAAAAAAAAAA;
      b_exp_st = '0; b_exp_st[0] = 64'hFFFEFDFCFBFAF9F8; b_exp_st[1] = 64'h0706050403020100;
      b_exp_st[4] = 64'hAAAAAAAAAAAAAAAA; b_exp_cnt = 3;
      tick();
      b_clr = 1; b_st = '0; b_data = '0;
      b_exp_st = '0; b_exp_cnt = 1;
      tick();
      b_valid = 0; b_clr = 0;
      tick();

      // Reset while holding a stalled result
      a_valid = 1; a_st = '0; a_data = 64'h7; a_exp_st = '0; a_exp_st[0] = 64'h7; a_exp_cnt = 4;
      a_iready = 0;
      tick();
      a_valid = 0;
      chk("pre_rst_full", 320'(a_ovalid), 320'(1));
      rst_n = 0;
      tick();
      qa_st.delete(); qa_cnt.delete(); qb_st.delete(); qb_cnt.delete();
      chk("mid_rst_valid", 320'(a_ovalid), 320'(0));
      chk("mid_rst_state", a_ost, 320'(0));
      chk("mid_rst_count", 320'(a_cnt), 320'(0));
      chk("mid_rst_ready", 320'(a_ready), 320'(1));
      chk("mid_rst_b_count", 320'(b_cnt), 320'(0));
      rst_n = 1; a_iready = 1;

      for (int k = 0; k < 3; k++) tick();
      chk("final_a_queue", 320'(qa_st.size()), 320'(0));
      chk("final_b_queue", 320'(qb_st.size()), 320'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/xor_absorb_stage.md
Name: xor_absorb_stage

Overview:
- Registered, parametrised XOR stage that sits at the input of the ASCON permutation.
- Absorbs a RATE_WORDS x 64-bit data block into the rate rows, with optional in-block padding.
- Optionally injects the 128-bit key into the capacity rows just after the rate, and optionally applies domain separation on row 4.
- Covers both ASCON-128 (RATE_WORDS=1) and ASCON-128a (RATE_WORDS=2), with a valid/ready handshake on both sides and a per-message absorbed-block counter.

Parameters:
- RATE_WORDS, 1, number of 64-bit rate rows absorbed per block; legal values 1 or 2.
- CNT_WIDTH, 16, width of the absorbed-block counter.
- Derived BYTES_W = $clog2(8*RATE_WORDS+1).

Ports:
- i_clock  in  1  system clock
- i_reset_n  in  1  synchronous reset, active low
- i_state  in  t_state_array (5x64)  input state array
- i_valid  in  1  input transaction valid
- o_ready  out  1  stage can accept an input
- i_data  in  64*RATE_WORDS  data block; word w maps to row w; bytes big-endian within each row
- i_data_bytes  in  BYTES_W  number of valid data bytes, 0..8*RATE_WORDS
- i_key  in  128  key
- i_enable_xor_data  in  1  XOR data into the rate rows
- i_enable_pad  in  1  apply ASCON padding to the data block
- i_enable_xor_key  in  1  XOR key into rows RATE_WORDS and RATE_WORDS+1
- i_domain_sep  in  1  XOR 1 into bit 0 of row 4
- i_clear_count  in  1  clear the block counter (start of message)
- o_state  out  t_state_array (5x64)  registered output state
- o_valid  out  1  output valid
- i_ready  in  1  downstream accept
- o_block_count  out  CNT_WIDTH  blocks absorbed since last clear

Behaviour:
- Reset: synchronous, taken when i_reset_n=0 at a rising edge of i_clock.
  - o_state = 0, o_valid = 0, o_block_count = 0.
  - o_ready = 1 in the first cycle after reset.
  - Reset mid-transaction discards any held output with no handshake.
- Handshake:
  - Two-state FSM: EMPTY (o_valid=0) and FULL (o_valid=1).
  - o_ready = !o_valid || i_ready (combinational pass-through of i_ready).
  - An input is accepted when i_valid && o_ready.
  - EMPTY + accept -> FULL.
  - FULL + i_ready + no accept -> EMPTY.
  - FULL + i_ready + accept -> FULL with the new result; back-to-back throughput is 1 per cycle.
  - FULL + !i_ready -> hold; o_state and o_valid are stable.
- Latency: an accepted input appears on o_state/o_valid on the next cycle.
- Data path (computed on the accepted input):
  - Rate rows 0..RATE_WORDS-1 = i_state ^ D when i_enable_xor_data=1; otherwise the rows pass unchanged.
  - Padding off: D = i_data.
  - Padding on, n = i_data_bytes: bytes 0..n-1 of i_data are kept, bytes n..8*RATE_WORDS-1 are zeroed, and byte n (if n < 8*RATE_WORDS) is replaced by 0x80.
  - Byte b sits in row b/8, bits [63-8*(b%8) -: 8].
  - n = 8*RATE_WORDS with padding on: full block, no pad byte. The caller sends a following block with n=0, which yields 0x80 in row 0 bits [63:56].
  - n > 8*RATE_WORDS: clamped to 8*RATE_WORDS.
  - i_data_bytes is ignored when i_enable_pad=0.
- Key: when i_enable_xor_key=1, row RATE_WORDS ^= i_key[127:64] and row RATE_WORDS+1 ^= i_key[63:0].
- Domain separation: when i_domain_sep=1, row 4 bit 0 ^= 1.
  - It is applied after the key XOR; with RATE_WORDS=2 and key enabled, row 3 takes the key while row 4 takes the separation bit.
- Unaffected rows pass through unchanged.
- Counter:
  - Increments by 1 on each accepted input with i_enable_xor_data=1.
  - Saturates at all-ones; no wrap.
  - i_clear_count on an accepted cycle loads 1 if that input absorbs data, else 0.
  - i_clear_count with no accept loads 0.
  - Clear has priority over saturation.
- Inputs sampled while not accepted have no effect.
- RATE_WORDS outside {1,2}: elaboration error.

Test Plan:
- RATE_WORDS=1, state=0, i_data=64'h0123456789ABCDEF, data enabled, pad off, i_ready=1 -> next cycle o_valid=1, row0=64'h0123456789ABCDEF, rows 1..4=0, o_block_count=1.
- RATE_WORDS=1, pad on, i_data_bytes=3, i_data=64'hAABBCCDDEEFF0011, state=0 -> row0=64'hAABBCC8000000000; pad on with bytes=0 -> row0=64'h8000000000000000.
- RATE_WORDS=2, key=128'h00112233445566778899AABBCCDDEEFF, key enabled, domain_sep=1, state=0 -> row2=64'h0011223344556677, row3=64'h8899AABBCCDDEEFF, row4=64'h1, rows 0..1=0.
- Backpressure: three back-to-back valid inputs with i_ready held 0 for 2 cycles after the first -> o_state holds the first result, o_ready=0, the 2nd input is held by the source; after i_ready=1 all three results emerge in order with no loss or duplication.
- Counter: 5 data-absorbing accepts, then i_clear_count with a data accept -> count goes 1..5 then 1; CNT_WIDTH=2 with 6 accepts -> count saturates at 3.
- Reset mid-operation: i_reset_n=0 while FULL and !i_ready -> next cycle o_valid=0, o_state=0, o_block_count=0, o_ready=1.
